// File: rtl/key_sched_if.sv
// Key handshake, status and round-key read bus for key_sched_seq.
interface key_sched_if;
  logic         key_valid;
  logic         key_ready;
  logic [255:0] key;
  logic [1:0]   key_len;
  logic         busy;
  logic         done;
  logic         err;
  logic         keys_valid;
  logic [3:0]   nr;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;

  modport master (
    output key_valid, key, key_len, rk_addr,
    input  key_ready, busy, done, err, keys_valid, nr, rk_data
  );

  modport slave (
    input  key_valid, key, key_len, rk_addr,
    output key_ready, busy, done, err, keys_valid, nr, rk_data
  );
endinterface

// File: rtl/key_sched_seq.sv
// Iterative AES-128/192/256 key expander: one schedule word per cycle via one shared 4-byte S-box.
// Optional KEY_SCHED_ZEROIZE_EN adds a zeroize input that aborts generation and wipes storage.
module key_sched_seq #(
  parameter int MAX_NR    = 14,
  parameter bit RK_RD_REG = 1'b1
) (
  input  logic clk,
  input  logic rst,
`ifdef KEY_SCHED_ZEROIZE_EN
  input  logic zeroize,
`endif
  key_sched_if.slave bus
);

  localparam int WORDS = 4 * (MAX_NR + 1);
  localparam int AW    = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, GEN, ZERO} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  state_t        state, state_nxt;
  logic [31:0]   w_mem [WORDS];
  logic [AW-1:0] idx;
  logic [AW-1:0] t_last;
  logic [3:0]    nk, nk_new;
  logic [3:0]    nr_new, nr_lat, nr_q;
  logic [2:0]    jmod;
  logic [7:0]    rcon;
  logic          kv_q, done_q, err_q;
  logic          accept, legal_len, last_word, zero_req;
  logic [31:0]   prev_word, back_word, sb_in, sb_out, temp, new_word;
  logic [AW-1:0] base;
  logic [127:0]  rd_word;

`ifdef KEY_SCHED_ZEROIZE_EN
  assign zero_req = zeroize && (state != ZERO);
`else
  assign zero_req = 1'b0;
`endif

  always_comb begin
    nk_new = 4'd4;
    nr_new = 4'd10;
    case (bus.key_len)
      2'b01:   begin nk_new = 4'd6; nr_new = 4'd12; end
      2'b10:   begin nk_new = 4'd8; nr_new = 4'd14; end
      default: begin nk_new = 4'd4; nr_new = 4'd10; end
    endcase
  end

  assign legal_len      = (bus.key_len != 2'b11) && (nr_new <= 4'(MAX_NR));
  assign accept         = bus.key_valid && (state == IDLE);
  assign last_word      = (idx == t_last);
  assign bus.key_ready  = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.keys_valid = kv_q;
  assign bus.nr         = nr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && legal_len) state_nxt = GEN;
      GEN:     if (last_word) state_nxt = IDLE;
      ZERO:    if (idx == AW'(WORDS - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (zero_req) state_nxt = ZERO;
  end

  // Word generator: i mod Nk is tracked by jmod, which wraps at Nk-1.
  always_comb begin
    prev_word = w_mem[idx - AW'(1)];
    back_word = w_mem[idx - AW'(nk)];
    sb_in     = (jmod == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    sb_out    = sub_word(sb_in);
    if (jmod == 3'd0)                       temp = sb_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && jmod == 3'd4)    temp = sb_out;
    else                                    temp = prev_word;
    new_word  = back_word ^ temp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kv_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      nr_q   <= 4'd0;
      nr_lat <= 4'd0;
      nk     <= 4'd4;
      t_last <= '0;
      idx    <= '0;
      jmod   <= 3'd0;
      rcon   <= 8'h01;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (zero_req) begin
        kv_q <= 1'b0;
        nr_q <= 4'd0;
        idx  <= '0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            kv_q  <= 1'b0;
            nr_q  <= 4'd0;
            err_q <= !legal_len;
            if (legal_len) begin
              nk     <= nk_new;
              nr_lat <= nr_new;
              t_last <= AW'({nr_new, 2'b00} + 6'd3);
              idx    <= AW'(nk_new);
              jmod   <= 3'd0;
              rcon   <= 8'h01;
            end
          end
          GEN: begin
            idx  <= idx + AW'(1);
            jmod <= (jmod == 3'(nk - 4'd1)) ? 3'd0 : jmod + 3'd1;
            if (jmod == 3'd0) rcon <= xtime(rcon);
            if (last_word) begin
              kv_q   <= 1'b1;
              nr_q   <= nr_lat;
              done_q <= 1'b1;
            end
          end
          ZERO:    idx <= idx + AW'(1);
          default: idx <= '0;
        endcase
      end
    end
  end

  // Schedule storage holds data only, so it carries no reset; kv_q masks stale contents.
  always_ff @(posedge clk) begin
    if (accept && legal_len && !zero_req) begin
      for (int k = 0; k < 8; k++)
        if (4'(k) < nk_new) w_mem[AW'(k)] <= bus.key[255 - 32 * k -: 32];
    end else if (state == GEN && !zero_req) begin
      w_mem[idx] <= new_word;
    end else if (state == ZERO) begin
      w_mem[idx] <= 32'h0;
    end
  end

  assign base    = AW'({bus.rk_addr, 2'b00});
  assign rd_word = (kv_q && bus.rk_addr <= nr_q) ?
                   {w_mem[base], w_mem[base + AW'(1)], w_mem[base + AW'(2)], w_mem[base + AW'(3)]} :
                   128'h0;

  generate
    if (RK_RD_REG) begin : g_rd_reg
      logic [127:0] rk_p0;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) rk_p0 <= 128'h0;
        else     rk_p0 <= rd_word;
      end
      assign bus.rk_data = rk_p0;
    end else begin : g_rd_comb
      assign bus.rk_data = rd_word;
    end
  endgenerate

endmodule

// File: tb/tb_key_sched_seq.sv
// Scoreboard bench for key_sched_seq: FIPS-197 vectors, handshake corner cases, reset and zeroize.
module tb_key_sched_seq;

  typedef struct {
    int         cyc;
    logic [3:0] nr;
  } done_exp_t;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_req = 1'b0;
  logic rd_pend = 1'b0;
  int   pcnt = 0;
  int   checks = 0;
  int   errors = 0;
  done_exp_t    done_q[$];
  logic [127:0] rd_q[$];

  key_sched_if bus ();
`ifdef KEY_SCHED_ZEROIZE_EN
  logic zeroize = 1'b0;
`endif

  key_sched_seq dut (
    .clk(clk),
    .rst(rst),
`ifdef KEY_SCHED_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pcnt    <= pcnt + 1;
    rd_pend <= rd_req;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares done pulses and read data against the expectation queues.
  always @(negedge clk) begin
    done_exp_t e;
    if (bus.done) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got done=1 at cycle %0d expected no done", pcnt);
      end else begin
        e = done_q.pop_front();
        chk("done_cycle", 256'(pcnt), 256'(e.cyc));
        chk("done_nr", 256'(bus.nr), 256'(e.nr));
        chk("done_keys_valid", 256'(bus.keys_valid), 256'd1);
      end
    end
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got read response %0h expected none", bus.rk_data);
      end else begin
        chk("rk_data", 256'(bus.rk_data), 256'(rd_q.pop_front()));
      end
    end
  end

  task automatic offer(input logic [255:0] k, input logic [1:0] len, input int lat,
                       input logic [3:0] nrv, input bit expect_done);
    done_exp_t e;
    bus.key       = k;
    bus.key_len   = len;
    bus.key_valid = 1'b1;
    if (expect_done) begin
      e.cyc = pcnt + lat;
      e.nr  = nrv;
      done_q.push_back(e);
    end
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic wait_kv();
    for (int c = 0; c < 200 && !bus.keys_valid; c++) @(negedge clk);
    chk("keys_valid_wait", 256'(bus.keys_valid), 256'd1);
  endtask

  task automatic read_rk(input logic [3:0] a, input logic [127:0] exp);
    bus.rk_addr = a;
    rd_req      = 1'b1;
    rd_q.push_back(exp);
    @(negedge clk);
  endtask

  task automatic read_end();
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_key_ready"}, 256'(bus.key_ready), 256'd1);
    chk({tag, "_busy"}, 256'(bus.busy), 256'd0);
    chk({tag, "_done"}, 256'(bus.done), 256'd0);
    chk({tag, "_err"}, 256'(bus.err), 256'd0);
    chk({tag, "_keys_valid"}, 256'(bus.keys_valid), 256'd0);
    chk({tag, "_nr"}, 256'(bus.nr), 256'd0);
    chk({tag, "_rk_data"}, 256'(bus.rk_data), 256'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time limit expected $finish");
    $fatal(1);
  end

  initial begin
    bus.key_valid = 1'b0;
    bus.key       = '0;
    bus.key_len   = 2'b00;
    bus.rk_addr   = 4'd0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("post_reset");

    // AES-128
    offer(K128, 2'b00, 41, 4'd10, 1'b1);
    chk("busy_gen128", 256'(bus.busy), 256'd1);
    chk("key_ready_gen128", 256'(bus.key_ready), 256'd0);
    wait_kv();
    chk("nr_128", 256'(bus.nr), 256'd10);
    read_rk(4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    read_rk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk(4'd11, 128'h0);
    read_end();

    // AES-192
    offer(K192, 2'b01, 47, 4'd12, 1'b1);
    wait_kv();
    read_rk(4'd0, 128'h8e73b0f7da0e6452c810f32b809079e5);
    read_rk(4'd12, 128'he98ba06f448c773c8ecc720401002202);
    read_rk(4'd13, 128'h0);
    read_end();

    // AES-256 with key_valid held through GEN, then a second key taken on the done cycle
    bus.key       = K256;
    bus.key_len   = 2'b10;
    bus.key_valid = 1'b1;
    begin
      done_exp_t e;
      e.cyc = pcnt + 53;
      e.nr  = 4'd14;
      done_q.push_back(e);
    end
    @(negedge clk);
    bus.key     = K128;
    bus.key_len = 2'b00;
    chk("key_ready_held", 256'(bus.key_ready), 256'd0);
    for (int c = 0; c < 100 && !bus.done; c++) @(negedge clk);
    chk("b2b_done_seen", 256'(bus.done), 256'd1);
    chk("b2b_key_ready_on_done", 256'(bus.key_ready), 256'd1);
    begin
      done_exp_t e;
      e.cyc = pcnt + 41;
      e.nr  = 4'd10;
      done_q.push_back(e);
    end
    @(negedge clk);
    bus.key_valid = 1'b0;
    chk("b2b_keys_valid_drop", 256'(bus.keys_valid), 256'd0);
    chk("b2b_nr_drop", 256'(bus.nr), 256'd0);
    chk("b2b_busy", 256'(bus.busy), 256'd1);
    wait_kv();
    read_rk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_end();

    // Reserved key length
    bus.key_len   = 2'b11;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    chk("err_pulse", 256'(bus.err), 256'd1);
    chk("err_keys_valid", 256'(bus.keys_valid), 256'd0);
    chk("err_nr", 256'(bus.nr), 256'd0);
    chk("err_key_ready", 256'(bus.key_ready), 256'd1);
    chk("err_busy", 256'(bus.busy), 256'd0);
    @(negedge clk);
    chk("err_one_cycle", 256'(bus.err), 256'd0);
    read_rk(4'd0, 128'h0);
    read_end();

    // Reset in cycle 20 of an AES-256 run, then a clean re-run
    offer(K256, 2'b10, 53, 4'd14, 1'b0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_idle_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    offer(K256, 2'b10, 53, 4'd14, 1'b1);
    wait_kv();
    read_rk(4'd0, 128'h603deb1015ca71be2b73aef0857d7781);
    read_rk(4'd1, 128'h1f352c073b6108d72d9810a30914dff4);
    read_rk(4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
    read_rk(4'd15, 128'h0);
    read_end();

`ifdef KEY_SCHED_ZEROIZE_EN
    begin
      int n;
      int bad;
      n   = 0;
      bad = 0;
      zeroize = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
      while (bus.busy && n < 200) begin
        n++;
        if (bus.key_ready || bus.keys_valid) bad++;
        @(negedge clk);
      end
      chk("zeroize_busy_cycles", 256'(n), 256'd60);
      chk("zeroize_ready_kv_low", 256'(bad), 256'd0);
      chk("zeroize_keys_valid", 256'(bus.keys_valid), 256'd0);
      for (int a = 0; a <= 14; a++) read_rk(4'(a), 128'h0);
      read_end();
    end
`endif

    repeat (3) @(negedge clk);
    chk("done_queue_empty", 256'(done_q.size()), 256'd0);
    chk("read_queue_empty", 256'(rd_q.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_sched_seq.md
# key_sched_seq

Sequential, multi-length AES key-schedule engine for the GCM datapath. It replaces the flat 256-bit combinational expander with an iterative core. The core accepts a 128-, 192- or 256-bit key, generates one schedule word per cycle through a single shared 4-byte S-box, and stores up to 60 words internally. The round datapath fetches one 128-bit round key per cycle through a registered read port.

## Interface
Parameters:
- `MAX_NR`, default 14: maximum supported round count; storage holds 4*(MAX_NR+1) words. Legal values are 10, 12, 14.
- `RK_RD_REG`, default 1: 1 = registered read port (1-cycle latency); 0 = combinational read.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `key_valid` in 1: key offer.
- `key_ready` out 1: high only in IDLE.
- `key` in 256: key, MSB-aligned. AES-128 uses [255:128]; AES-192 uses [255:64].
- `key_len` in 2: key length. 00 = 128, 01 = 192, 10 = 256, 11 = reserved.
- `busy` out 1: high in GEN.
- `done` out 1: 1-cycle pulse when the schedule is complete.
- `err` out 1: 1-cycle pulse when a key is accepted with `key_len` = 11.
- `keys_valid` out 1: stored schedule is complete and readable.
- `nr` out 4: round count of the stored schedule (10/12/14); 0 when not valid.
- `rk_addr` in 4: round-key index, 0..nr.
- `rk_data` out 128: round key; {w[4i], w[4i+1], w[4i+2], w[4i+3]}, with w[4i] in [127:96].

## Operation
- Derived per length: Nk = 4/6/8, Nr = 10/12/14, total words T = 44/52/60.
- States: IDLE, GEN.
- **IDLE → GEN** on `key_valid && key_ready` with a legal `key_len`:
  - Write w[0..Nk-1] from `key` in one cycle.
  - Clear `keys_valid`; latch Nk and T.
  - Set word index i = Nk and rcon = 0x01.
- **GEN**, one word per cycle:
  - temp = w[i-1].
  - If i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon). The sequence is 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - Else if Nk = 8 and i mod 8 = 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp; i++.
  - Compute i mod Nk with a wrapping counter, not a divider.
- **GEN → IDLE** after writing w[T-1]: set `keys_valid`, set `nr` = Nr, pulse `done`.
- Reserved `key_len` (11):
  - The key is accepted (handshake completes) and `err` pulses.
  - State stays IDLE.
  - `keys_valid` clears and `nr` is 0.
- `key_valid` during GEN is ignored because `key_ready` is 0. The key must be re-offered.
- Reads:
  - When `keys_valid` = 0, `rk_data` = 0.
  - When `rk_addr` > `nr`, `rk_data` = 0.
  - Reads in IDLE never disturb storage.
- A new accepted key invalidates the previous schedule immediately, in the acceptance cycle.
- `rst` asserted in any state:
  - State returns to IDLE.
  - `keys_valid`, `busy`, `done`, `err` = 0; `nr` = 0; `rk_data` = 0.
  - Storage contents are unspecified, and are masked by `keys_valid` = 0.

## Timing
- Acceptance edge: cycle 0. GEN occupies cycles 1..T-Nk, i.e. 40/46/52 cycles.
- `done` and `keys_valid` are first high in cycle T-Nk+1 (41/47/53). `key_ready` returns high in that same cycle.
- Back-to-back keys are allowed: a new key can be accepted on the `done` cycle.
- Read latency:
  - `RK_RD_REG` = 1: `rk_data` reflects `rk_addr` sampled at the previous edge.
  - `RK_RD_REG` = 0: `rk_data` reflects the current `rk_addr`.
- Reset values: `key_ready` = 1 (IDLE); all other outputs 0.

## Configuration
- Macro `KEY_SCHED_ZEROIZE_EN`.
- Defined:
  - Adds input `zeroize` (1 bit).
  - A 1-cycle assertion aborts GEN and returns the block to IDLE.
  - The block then spends exactly T_max = 4*(MAX_NR+1) cycles writing 0 to every storage word. During this time `busy` = 1, `key_ready` = 0 and `keys_valid` = 0.
  - `done` does not pulse.
  - `zeroize` has priority over key acceptance in the same cycle.
- Undefined: no `zeroize` port; storage is retained until it is overwritten.

## Test plan
- **AES-128 (FIPS-197):** key 2b7e151628aed2a6abf7158809cf4f3c.
  - `done` 41 cycles after acceptance.
  - rk[0] = the key.
  - rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `nr` = 10.
- **AES-192:** key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - `done` at cycle 47.
  - rk[12] = e98ba06f448c773c8ecc720401002202.
  - rk[13] reads 0.
- **AES-256:** key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - `done` at cycle 53.
  - rk[14] = fe4890d1e6188d0b046df344706c631e.
- **Handshake:**
  - `key_valid` held during GEN is not accepted.
  - A second key offered on the `done` cycle is accepted and `keys_valid` drops the next cycle.
  - `key_len` = 11 gives an `err` pulse, `keys_valid` = 0 and `nr` = 0.
- **Reset mid-GEN:** assert `rst` at cycle 20 of an AES-256 run.
  - All outputs are 0 and `key_ready` = 1.
  - A re-run produces the correct rk[14].
- **`KEY_SCHED_ZEROIZE_EN`:** zeroize after a complete schedule.
  - `busy` is high for 60 cycles.
  - Afterwards all rk read 0 and `done` never pulses.
